// File: rtl/enc_pkg.sv
// Shared definitions for the RGB -> YUV encoder: FSM encoding, default frame layout, coefficients.
// ENC_UV_AVG_EN selects averaged (defined) or even-pixel (undefined) chroma subsampling.
package enc_pkg;

    typedef enum logic [3:0] {
        S_ENC_IDLE,
        S_ENC_RD0, S_ENC_RD1, S_ENC_RD2, S_ENC_RD3,
        S_ENC_RD4, S_ENC_RD5, S_ENC_RD6, S_ENC_RD7,
        S_ENC_WY0, S_ENC_WY1, S_ENC_WU, S_ENC_WV,
        S_ENC_DONE
    } enc_state_e;

    localparam int RGB_BASE_DEF   = 146944;
    localparam int Y_BASE_DEF     = 0;
    localparam int U_BASE_DEF     = 38400;
    localparam int V_BASE_DEF     = 57600;
    localparam int NUM_GROUPS_DEF = 19200;

    localparam logic signed [17:0] C_Y_R =  18'sd66;
    localparam logic signed [17:0] C_Y_G =  18'sd129;
    localparam logic signed [17:0] C_Y_B =  18'sd25;
    localparam logic signed [17:0] C_U_R = -18'sd38;
    localparam logic signed [17:0] C_U_G = -18'sd74;
    localparam logic signed [17:0] C_U_B =  18'sd112;
    localparam logic signed [17:0] C_V_R =  18'sd112;
    localparam logic signed [17:0] C_V_G = -18'sd94;
    localparam logic signed [17:0] C_V_B = -18'sd18;

    // Chroma value for one pixel pair: rounded mean, or the even pixel alone.
    function automatic logic [7:0] uv_pair(input logic [7:0] a, input logic [7:0] b);
`ifdef ENC_UV_AVG_EN
        return 8'((9'(a) + 9'(b) + 9'd1) >> 1);
`else
        return a;
`endif
    endfunction

endpackage

// File: rtl/rgb2yuv_pixel.sv
// Combinational conversion of one 8-bit RGB pixel to 8-bit Y, U, V.
// The fixed coefficients keep every result inside 16..240, so plain truncation is exact.
module rgb2yuv_pixel
    import enc_pkg::*;
(
    input  logic [7:0] r_i,
    input  logic [7:0] g_i,
    input  logic [7:0] b_i,
    output logic [7:0] y_o,
    output logic [7:0] u_o,
    output logic [7:0] v_o
);

    logic signed [17:0] r_s, g_s, b_s;
    logic signed [17:0] y_sum_s, u_sum_s, v_sum_s;

    assign r_s = signed'({10'd0, r_i});
    assign g_s = signed'({10'd0, g_i});
    assign b_s = signed'({10'd0, b_i});

    assign y_sum_s = C_Y_R * r_s + C_Y_G * g_s + C_Y_B * b_s + 18'sd128;
    assign u_sum_s = C_U_R * r_s + C_U_G * g_s + C_U_B * b_s + 18'sd128;
    assign v_sum_s = C_V_R * r_s + C_V_G * g_s + C_V_B * b_s + 18'sd128;

    // Arithmetic shift floors negative chroma partial sums before the offset is added.
    assign y_o = 8'((y_sum_s >>> 8) + 18'sd16);
    assign u_o = 8'((u_sum_s >>> 8) + 18'sd128);
    assign v_o = 8'((v_sum_s >>> 8) + 18'sd128);

endmodule

// File: rtl/rgb_yuv_encoder.sv
// Frame encoder: reads packed RGB groups of 4 pixels from SRAM and writes Y, U and V planes.
// ENC_UV_AVG_EN (via enc_pkg::uv_pair) selects averaged versus even-pixel chroma.
module rgb_yuv_encoder
    import enc_pkg::*;
#(
    parameter int RGB_BASE   = RGB_BASE_DEF,
    parameter int Y_BASE     = Y_BASE_DEF,
    parameter int U_BASE     = U_BASE_DEF,
    parameter int V_BASE     = V_BASE_DEF,
    parameter int NUM_GROUPS = NUM_GROUPS_DEF
) (
    input  logic        CLOCK_50_I,
    input  logic        Reset,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    input  logic        Enc_start,
    output logic        Enc_done
);

    localparam logic [17:0] LAST_GRP = 18'(NUM_GROUPS - 1);

    enc_state_e       state_q, state_d;
    logic [17:0]      grp_q, grp_d;
    logic             start_q;
    logic [17:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             we_n_q, we_n_d;
    logic             done_q, done_d;
    logic [5:0][15:0] word_q;
    logic [3:0][7:0]  u_q, v_q;

    logic             sel_b_s;
    logic [2:0][15:0] pair_s;
    logic [17:0]      rgb_grp_s;
    logic [7:0]       y0_s, u0_s, v0_s, y1_s, u1_s, v1_s;

    // Pixels 0/1 are converted while finishing the reads, pixels 2/3 during the first Y write.
    assign sel_b_s   = (state_q == S_ENC_WY0);
    assign pair_s    = sel_b_s ? word_q[5:3] : word_q[2:0];
    assign rgb_grp_s = 18'(RGB_BASE) + (grp_d << 2) + (grp_d << 1);

    rgb2yuv_pixel u_pix0 (
        .r_i(pair_s[0][15:8]), .g_i(pair_s[0][7:0]), .b_i(pair_s[1][15:8]),
        .y_o(y0_s), .u_o(u0_s), .v_o(v0_s)
    );

    rgb2yuv_pixel u_pix1 (
        .r_i(pair_s[1][7:0]), .g_i(pair_s[2][15:8]), .b_i(pair_s[2][7:0]),
        .y_o(y1_s), .u_o(u1_s), .v_o(v1_s)
    );

    // State, group counter and latched start request; a start seen in DONE is kept for the following IDLE.
    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            state_q <= S_ENC_IDLE;
            grp_q   <= 18'd0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            start_q <= Enc_start & ((state_q == S_ENC_IDLE) | (state_q == S_ENC_DONE));
        end
    end

    // Next-state and group sequencing: twelve states per group.
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        case (state_q)
            S_ENC_IDLE: begin
                grp_d = 18'd0;
                if (start_q) state_d = S_ENC_RD0;
                else         state_d = S_ENC_IDLE;
            end
            S_ENC_RD0:  state_d = S_ENC_RD1;
            S_ENC_RD1:  state_d = S_ENC_RD2;
            S_ENC_RD2:  state_d = S_ENC_RD3;
            S_ENC_RD3:  state_d = S_ENC_RD4;
            S_ENC_RD4:  state_d = S_ENC_RD5;
            S_ENC_RD5:  state_d = S_ENC_RD6;
            S_ENC_RD6:  state_d = S_ENC_RD7;
            S_ENC_RD7:  state_d = S_ENC_WY0;
            S_ENC_WY0:  state_d = S_ENC_WY1;
            S_ENC_WY1:  state_d = S_ENC_WU;
            S_ENC_WU:   state_d = S_ENC_WV;
            S_ENC_WV: begin
                if (grp_q == LAST_GRP) begin
                    state_d = S_ENC_DONE;
                    grp_d   = 18'd0;
                end else begin
                    state_d = S_ENC_RD0;
                    grp_d   = grp_q + 18'd1;
                end
            end
            S_ENC_DONE: state_d = S_ENC_IDLE;
            default:    state_d = S_ENC_IDLE;
        endcase
    end

    // SRAM command and done pulse for the state being entered, so they register in step with it.
    always_comb begin
        addr_d  = 18'd0;
        we_n_d  = 1'b1;
        wdata_d = 16'd0;
        done_d  = 1'b0;
        case (state_d)
            S_ENC_RD0: addr_d = rgb_grp_s;
            S_ENC_RD1: addr_d = rgb_grp_s + 18'd1;
            S_ENC_RD2: addr_d = rgb_grp_s + 18'd2;
            S_ENC_RD3: addr_d = rgb_grp_s + 18'd3;
            S_ENC_RD4: addr_d = rgb_grp_s + 18'd4;
            S_ENC_RD5: addr_d = rgb_grp_s + 18'd5;
            S_ENC_WY0: begin
                addr_d  = 18'(Y_BASE) + (grp_d << 1);
                we_n_d  = 1'b0;
                wdata_d = {y0_s, y1_s};
            end
            S_ENC_WY1: begin
                addr_d  = 18'(Y_BASE) + (grp_d << 1) + 18'd1;
                we_n_d  = 1'b0;
                wdata_d = {y0_s, y1_s};
            end
            S_ENC_WU: begin
                addr_d  = 18'(U_BASE) + grp_d;
                we_n_d  = 1'b0;
                wdata_d = {uv_pair(u_q[0], u_q[1]), uv_pair(u_q[2], u_q[3])};
            end
            S_ENC_WV: begin
                addr_d  = 18'(V_BASE) + grp_d;
                we_n_d  = 1'b0;
                wdata_d = {uv_pair(v_q[0], v_q[1]), uv_pair(v_q[2], v_q[3])};
            end
            S_ENC_DONE: done_d = 1'b1;
            default:    done_d = 1'b0;
        endcase
    end

    // Registered SRAM interface and completion pulse.
    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            addr_q  <= 18'd0;
            we_n_q  <= 1'b1;
            wdata_q <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            we_n_q  <= we_n_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    // Read data lands two cycles after its address, so RD2..RD7 capture words 0..5.
    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            word_q <= {6{16'd0}};
            u_q    <= {4{8'd0}};
            v_q    <= {4{8'd0}};
        end else begin
            case (state_q)
                S_ENC_RD2: word_q[0] <= SRAM_read_data;
                S_ENC_RD3: word_q[1] <= SRAM_read_data;
                S_ENC_RD4: word_q[2] <= SRAM_read_data;
                S_ENC_RD5: word_q[3] <= SRAM_read_data;
                S_ENC_RD6: word_q[4] <= SRAM_read_data;
                S_ENC_RD7: begin
                    word_q[5] <= SRAM_read_data;
                    u_q[0]    <= u0_s;
                    u_q[1]    <= u1_s;
                    v_q[0]    <= v0_s;
                    v_q[1]    <= v1_s;
                end
                S_ENC_WY0: begin
                    u_q[2] <= u0_s;
                    u_q[3] <= u1_s;
                    v_q[2] <= v0_s;
                    v_q[3] <= v1_s;
                end
                default: word_q <= word_q;
            endcase
        end
    end

    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;
    assign Enc_done        = done_q;

endmodule

// File: tb/tb_rgb_yuv_encoder.sv
// Self-checking bench for rgb_yuv_encoder on a reduced frame, with an SRAM model and a YUV reference.
module tb_rgb_yuv_encoder;

    localparam int N     = 8;
    localparam int RGB_B = 146944;
    localparam int YB    = 0;
    localparam int UB    = 38400;
    localparam int VB    = 57600;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        we_n;
    logic        start;
    logic        done;

    int checks    = 0;
    int errors    = 0;
    int stray     = 0;
    int trace_bad = 0;
    int lat;

    logic [15:0] rgb_mem [0:6*N-1];
    logic [15:0] out_mem [0:262143];
    logic [15:0] rd_p1;

    always #5 clk = ~clk;

    rgb_yuv_encoder #(
        .RGB_BASE(RGB_B), .Y_BASE(YB), .U_BASE(UB), .V_BASE(VB), .NUM_GROUPS(N)
    ) dut (
        .CLOCK_50_I(clk), .Reset(rst),
        .SRAM_address(addr), .SRAM_write_data(wdata), .SRAM_we_n(we_n),
        .SRAM_read_data(rdata), .Enc_start(start), .Enc_done(done)
    );

    // SRAM model: two-cycle read latency; writes only allowed inside the Y/U/V planes.
    always @(posedge clk) begin
        if (addr >= RGB_B && addr < RGB_B + 6*N) rd_p1 <= rgb_mem[addr - RGB_B];
        else                                     rd_p1 <= 16'h0000;
        rdata <= rd_p1;
        if (!we_n) begin
            if ((addr >= YB && addr < YB + 2*N) || (addr >= UB && addr < UB + N) ||
                (addr >= VB && addr < VB + N))
                out_mem[addr] <= wdata;
            else
                stray <= stray + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fdiv256(input int t);
        if (t >= 0) return t / 256;
        else        return -((255 - t) / 256);
    endfunction

    function automatic logic [7:0] ycalc(input int r, input int g, input int b);
        return 8'(fdiv256(66*r + 129*g + 25*b + 128) + 16);
    endfunction

    function automatic logic [7:0] ucalc(input int r, input int g, input int b);
        return 8'(fdiv256(-38*r - 74*g + 112*b + 128) + 128);
    endfunction

    function automatic logic [7:0] vcalc(input int r, input int g, input int b);
        return 8'(fdiv256(112*r - 94*g - 18*b + 128) + 128);
    endfunction

    function automatic logic [7:0] sub(input int a, input int b);
`ifdef ENC_UV_AVG_EN
        return 8'((a + b + 1) / 2);
`else
        return 8'(a + 0 * b);
`endif
    endfunction

    // Pixel i (0..3) of group g, unpacked from the byte stream R0 G0 B0 R1 G1 B1.
    task automatic get_pix(input int g, input int i, output int r, output int gg, output int b);
        int by [6];
        logic [15:0] w;
        for (int j = 0; j < 3; j++) begin
            w = rgb_mem[6*g + 3*(i/2) + j];
            by[2*j]   = int'(w[15:8]);
            by[2*j+1] = int'(w[7:0]);
        end
        r  = by[3*(i%2)];
        gg = by[3*(i%2) + 1];
        b  = by[3*(i%2) + 2];
    endtask

    task automatic check_planes(input string tag);
        int r, g, b;
        int ys [4];
        int us [4];
        int vs [4];
        for (int grp = 0; grp < N; grp++) begin
            for (int i = 0; i < 4; i++) begin
                get_pix(grp, i, r, g, b);
                ys[i] = int'(ycalc(r, g, b));
                us[i] = int'(ucalc(r, g, b));
                vs[i] = int'(vcalc(r, g, b));
            end
            check($sformatf("%s_y01_g%0d", tag, grp), 32'(out_mem[YB + 2*grp]), 32'({8'(ys[0]), 8'(ys[1])}));
            check($sformatf("%s_y23_g%0d", tag, grp), 32'(out_mem[YB + 2*grp + 1]), 32'({8'(ys[2]), 8'(ys[3])}));
            check($sformatf("%s_u_g%0d", tag, grp), 32'(out_mem[UB + grp]), 32'({sub(us[0], us[1]), sub(us[2], us[3])}));
            check($sformatf("%s_v_g%0d", tag, grp), 32'(out_mem[VB + grp]), 32'({sub(vs[0], vs[1]), sub(vs[2], vs[3])}));
        end
    endtask

    task automatic fill_rgb(input bit directed);
        for (int i = 0; i < 6*N; i++) rgb_mem[i] = 16'($urandom);
        if (directed) begin
            for (int i = 0; i < 6; i++) rgb_mem[i] = 16'hFFFF;
            for (int i = 6; i < 12; i++) rgb_mem[i] = 16'h0000;
            rgb_mem[12] = 16'hFF00;
            rgb_mem[13] = 16'h0000;
            rgb_mem[14] = 16'h00FF;
        end
    endtask

    // Starts a frame from a negedge; k counts cycles after the start sample. Verifies the bus sequence.
    task automatic run_frame(input int p1, input int p2, output int latency);
        int p, g, ph;
        latency = -1;
        start   = 1'b1;
        for (int k = 1; k <= 12*N + 40; k++) begin
            @(negedge clk);
            start = (k == p1) || (k == p2);
            if (done) begin
                latency = k;
                break;
            end
            p  = k - 2;
            g  = p / 12;
            ph = p % 12;
            if (p < 0 || p >= 12*N) begin
                if (we_n !== 1'b1) trace_bad++;
            end else if (ph < 6) begin
                if (we_n !== 1'b1 || addr !== 18'(RGB_B + 6*g + ph)) trace_bad++;
            end else if (ph < 8) begin
                if (we_n !== 1'b1) trace_bad++;
            end else begin
                case (ph)
                    8:       if (we_n !== 1'b0 || addr !== 18'(YB + 2*g))     trace_bad++;
                    9:       if (we_n !== 1'b0 || addr !== 18'(YB + 2*g + 1)) trace_bad++;
                    10:      if (we_n !== 1'b0 || addr !== 18'(UB + g))       trace_bad++;
                    default: if (we_n !== 1'b0 || addr !== 18'(VB + g))       trace_bad++;
                endcase
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we_n", 32'(we_n), 32'd1);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);

        // Frame A: white, black and red/blue groups up front.
        fill_rgb(1'b1);
        run_frame(0, 0, lat);
        check("A_latency", 32'(lat), 32'(12*N + 2));
        check("A_white_y", 32'(out_mem[YB]), 32'h0000EBEB);
        check("A_white_u", 32'(out_mem[UB]), 32'h00008080);
        check("A_white_v", 32'(out_mem[VB]), 32'h00008080);
        check("A_black_y", 32'(out_mem[YB + 2]), 32'h00001010);
        check("A_black_u", 32'(out_mem[UB + 1]), 32'h00008080);
        check("A_redblue_y", 32'(out_mem[YB + 4]), 32'({8'd82, 8'd41}));
`ifdef ENC_UV_AVG_EN
        check("A_redblue_ua", 32'(out_mem[UB + 2][15:8]), 32'd165);
        check("A_redblue_va", 32'(out_mem[VB + 2][15:8]), 32'd175);
`else
        check("A_redblue_ua", 32'(out_mem[UB + 2][15:8]), 32'd90);
        check("A_redblue_va", 32'(out_mem[VB + 2][15:8]), 32'd240);
`endif
        check_planes("A");
        @(negedge clk);
        check("A_done_width", 32'(done), 32'd0);

        // Frame B: random data, stray start pulses mid-frame.
        fill_rgb(1'b0);
        run_frame(30, 12*N, lat);
        check("B_latency", 32'(lat), 32'(12*N + 2));
        check_planes("B");

        // Frame C then D: D is started in the very cycle C reports done.
        fill_rgb(1'b0);
        run_frame(0, 0, lat);
        check("C_latency", 32'(lat), 32'(12*N + 2));
        check_planes("C");
        fill_rgb(1'b0);
        run_frame(0, 0, lat);
        check("D_chain_latency", 32'(lat), 32'(12*N + 2));
        check_planes("D");
        @(negedge clk);

        // Frame E: reset while writing U of group 5, then a clean restart.
        fill_rgb(1'b0);
        start = 1'b1;
        for (int k = 1; k <= 72; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("E_in_wu_we_n", 32'(we_n), 32'd0);
        check("E_in_wu_addr", 32'(addr), 32'(UB + 5));
        rst = 1'b1;
        @(negedge clk);
        check("E_rst_we_n", 32'(we_n), 32'd1);
        check("E_rst_addr", 32'(addr), 32'd0);
        check("E_rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("E_post_rst_we_n", 32'(we_n), 32'd1);
        fill_rgb(1'b0);
        run_frame(0, 0, lat);
        check("E_latency", 32'(lat), 32'(12*N + 2));
        check_planes("E");

        @(negedge clk);
        check("bus_trace", 32'(trace_bad), 32'd0);
        check("stray_writes", 32'(stray), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rgb_yuv_encoder.md
RGB_YUV_ENCODER -- requirements
Module: rgb_yuv_encoder

Interface
REQ-001 SHALL have parameter RGB_BASE, 146944, first word of the packed RGB image.
REQ-002 SHALL have parameter Y_BASE, 0, first word of the Y plane.
REQ-003 SHALL have parameter U_BASE, 38400, first word of the U plane.
REQ-004 SHALL have parameter V_BASE, 57600, first word of the V plane.
REQ-005 SHALL have parameter NUM_GROUPS, 19200, number of 4-pixel groups (320x240/4).
REQ-006 SHALL have ports: CLOCK_50_I in 1, sole clock, all logic on rising edge; Reset in 1, synchronous active-high reset.
REQ-007 SHALL have ports: SRAM_address out 18, SRAM_write_data out 16, SRAM_we_n out 1 (active-low write), SRAM_read_data in 16.
REQ-008 SHALL have ports: Enc_start in 1, begin frame; Enc_done out 1, one-cycle completion pulse.

Function
REQ-009 SHALL read RGB packed 3 words per 2 pixels: {R0,G0}, {B0,R1}, {G1,B1}, high byte first.
REQ-010 SHALL process group g (4 pixels): read RGB_BASE+6g+0..5; write Y_BASE+2g={Y0,Y1}, Y_BASE+2g+1={Y2,Y3}, U_BASE+g={Ua,Ub}, V_BASE+g={Va,Vb}, where a = pixels 0/1 and b = pixels 2/3.
REQ-011 SHALL compute per pixel, in signed 18-bit minimum, with arithmetic shift: Y=((66R+129G+25B+128)>>>8)+16; U=((-38R-74G+112B+128)>>>8)+128; V=((112R-94G-18B+128)>>>8)+128.
REQ-012 SHALL keep the low 8 bits of each result; no saturation is needed because the coefficients bound the results to 16..240.
REQ-013 SHALL treat SRAM_read_data for an address driven in cycle n as valid for sampling in cycle n+2.
REQ-014 SHALL use FSM states S_ENC_IDLE, S_ENC_RD0..S_ENC_RD7, S_ENC_WY0, S_ENC_WY1, S_ENC_WU, S_ENC_WV, S_ENC_DONE.
REQ-015 SHALL drive addresses RGB+0..5 in RD0..RD5; RD6/RD7 only drain read latency.
REQ-016 SHALL drive one write per state in WY0, WY1, WU, WV, with SRAM_we_n low only in those states.
REQ-017 SHALL take exactly 12 cycles per group; S_ENC_WV SHALL go to RD0 of the next group, or to S_ENC_DONE after group NUM_GROUPS-1.
REQ-018 SHALL leave S_ENC_IDLE for RD0 on the cycle after Enc_start is sampled high.
REQ-019 SHALL ignore Enc_start outside S_ENC_IDLE.
REQ-020 SHALL assert Enc_done for exactly the one cycle spent in S_ENC_DONE, then return to S_ENC_IDLE.
REQ-021 SHALL make the total frame latency from the Enc_start sample to the Enc_done pulse 1+12*NUM_GROUPS+1 cycles.
REQ-022 SHALL restart from group 0 if Enc_start arrives in the same cycle Enc_done is high (the block is in S_ENC_IDLE the next cycle).

Reset
REQ-023 SHALL on Reset, including mid-frame, enter S_ENC_IDLE at the next edge.
REQ-024 SHALL on Reset set SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, Enc_done=0, group counter=0, and clear all pixel registers.
REQ-025 SHALL never issue a write in the cycle following a Reset assertion.

Configuration
REQ-026 SHALL provide macro ENC_UV_AVG_EN to select the U/V subsampling mode.
REQ-027 SHALL, when ENC_UV_AVG_EN is defined, produce Ua=(U0+U1+1)>>1 and likewise Ub/Va/Vb, using 9-bit sums.
REQ-028 SHALL, when ENC_UV_AVG_EN is undefined, produce Ua=U0, Ub=U2, Va=V0, Vb=V2 (even-pixel decimation).
REQ-029 SHALL keep identical cycle timing in both modes.

Structure
REQ-030 SHALL put the FSM enum, the base-address defaults and the 9 coefficients in shared package enc_pkg.
REQ-031 SHALL implement per-pixel conversion in sub-module rgb2yuv_pixel (8-bit R,G,B in; 8-bit Y,U,V out; combinational, result registered by the parent).
REQ-032 SHALL use two rgb2yuv_pixel instances, one per pixel of a pair.

Verification
REQ-033 SHALL cover group 0 all white (R=G=B=255) -> Y_BASE+0=16'hEBEB, U_BASE+0=16'h8080, V_BASE+0=16'h8080.
REQ-034 SHALL cover group 0 all black -> Y words 16'h1010, U/V words 16'h8080.
REQ-035 SHALL cover pixel 0 red (255,0,0) and pixel 1 blue (0,0,255) with ENC_UV_AVG_EN -> Y word {8'd82,8'd41}, Ua=(90+240+1)>>1=165, Va=(240+110+1)>>1=175. Without the macro -> Ua=90, Va=240.
REQ-036 SHALL cover a full frame -> Enc_done at exactly 230402 cycles after the Enc_start sample; final writes at 38399, 57599 and 76799; no write at or above 76800 except none.
REQ-037 SHALL cover Reset asserted during S_ENC_WU of group 5 -> SRAM_we_n high next cycle, state S_ENC_IDLE; a following Enc_start rewrites from group 0.
REQ-038 SHALL cover Enc_start pulsed mid-frame -> no effect on the address sequence or on the Enc_done timing.
